// File: rtl/timer_pkg.sv
// timer_counter shared definitions: FSM states,
// register word offsets, CTRL bit layout and mode codes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped interval timer beside data memory.
// One-shot or auto-reload countdown with masked irq.
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic        hit;
  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        en;
  logic        reload;
  logic        unused_addr;

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign off     = addr[3:2];
  assign wr_ctrl = we & hit & (off == OFF_CTRL);
  assign wr_pre  = we & hit & (off == OFF_PRESET);
  assign en      = ctrl_q[CTRL_EN];
  assign reload  =
    (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
  assign unused_addr = ^addr[1:0];

  assign irq = flag_q & ctrl_q[CTRL_IM];

  // Next state: FSM first, then CPU writes on top;
  // a flag set by the FSM wins over a CTRL-write clear.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    if (wr_ctrl) begin
      flag_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q == 32'd0) begin
          flag_d  = 1'b1;
          state_d = INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        if (reload) begin
          flag_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
    end
    if (wr_pre) begin
      preset_d = wdata;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Zero-latency read mux; misses and reserved read 0.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
        OFF_CTRL:   rdata = {28'd0, ctrl_q};
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues
// expected rdata/irq, negedge monitor pops and compares.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: one expected entry per cycle at most
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks = checks + 1;
      if (rdata !== e.rd || irq !== e.irq) begin
        errors = errors + 1;
        $display("FAIL %s: rdata=%0d irq=%0b expected rdata=%0d irq=%0b",
                 e.name, rdata, irq, e.rd, e.irq);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic chk(input logic [31:0] a, input logic [31:0] rd,
                     input logic ei, input string name);
    exp_t e;
    addr   = a;
    we     = 1'b0;
    e.name = name;
    e.rd   = rd;
    e.irq  = ei;
    sb.push_back(e);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int one_cnt[10] = '{0, 0, 5, 4, 3, 2, 1, 0, 0, 0};
  int ar_cnt[6]   = '{3, 2, 1, 0, 0, 0};
  int mid_cnt[4]  = '{0, 0, 10, 9};
  int re_cnt[3]   = '{7, 7, 10};
  int im_cnt[8]   = '{0, 0, 2, 1, 0, 0, 0, 0};
  int pw_cnt[6]   = '{2, 1, 0, 0, 0, 100};

  initial begin
    checks = 0;
    errors = 0;
    addr   = 32'd0;
    we     = 1'b0;
    wdata  = 32'd0;
    reset  = 1'b1;
    step();
    step();
    reset  = 1'b0;

    // reset state and window decode
    chk(A_CTRL, 32'd0, 1'b0, "rst_ctrl");
    chk(A_PRE,  32'd0, 1'b0, "rst_preset");
    chk(A_CNT,  32'd0, 1'b0, "rst_count");
    chk(A_RSV,  32'd0, 1'b0, "rsv_read");
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    wr(A_RSV, 32'hFFFF_FFFF);
    wr(A_CNT, 32'h1234);
    chk(A_CTRL, 32'd0, 1'b0, "miss_ctrl");
    chk(A_PRE,  32'd0, 1'b0, "miss_preset");
    chk(A_CNT,  32'd0, 1'b0, "ro_count");
    chk(BASE + 32'h14, 32'd0, 1'b0, "miss_read");

    // one-shot, PRESET=5, IM=1
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'hFFFF_FFF9);
    for (int k = 0; k < 10; k++)
      chk(A_CNT, one_cnt[k], k >= 8, $sformatf("os_cnt%0d", k));
    chk(A_CTRL, 32'd8, 1'b1, "os_ctrl_en_clr");
    chk(A_CTRL, 32'd8, 1'b1, "os_irq_hold");
    wr(A_CTRL, 32'd8);
    chk(A_CTRL, 32'd8, 1'b0, "os_irq_clr");

    // auto-reload, PRESET=3: pulse every 6 cycles
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'd11);
    for (int k = 0; k < 26; k++) begin
      if (k < 2)
        chk(A_CNT, 32'd0, 1'b0, $sformatf("ar_cnt%0d", k));
      else
        chk(A_CNT, ar_cnt[(k - 2) % 6], ((k - 2) % 6) == 4,
            $sformatf("ar_cnt%0d", k));
    end
    do_reset();

    // disable mid-count at COUNT=7, then re-enable
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'd9);
    for (int k = 0; k < 4; k++)
      chk(A_CNT, mid_cnt[k], 1'b0, $sformatf("mid_cnt%0d", k));
    wr(A_CTRL, 32'd0);
    chk(A_CNT, 32'd7, 1'b0, "mid_hold_a");
    chk(A_CNT, 32'd7, 1'b0, "mid_hold_b");
    chk(A_CNT, 32'd7, 1'b0, "mid_hold_c");
    wr(A_CTRL, 32'd9);
    for (int k = 0; k < 3; k++)
      chk(A_CNT, re_cnt[k], 1'b0, $sformatf("re_cnt%0d", k));
    do_reset();

    // masked one-shot, PRESET=2
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'd1);
    for (int k = 0; k < 8; k++)
      chk(A_CNT, im_cnt[k], 1'b0, $sformatf("im_cnt%0d", k));
    chk(A_CTRL, 32'd0, 1'b0, "im_en_clr");
    wr(A_CTRL, 32'd8);
    chk(A_CTRL, 32'd8, 1'b0, "im_flag_clr");
    do_reset();

    // PRESET write during CNT, then reset mid-count
    wr(A_PRE, 32'd4);
    wr(A_CTRL, 32'd11);
    chk(A_CNT, 32'd0, 1'b0, "pw_cnt0");
    chk(A_CNT, 32'd0, 1'b0, "pw_cnt1");
    chk(A_CNT, 32'd4, 1'b0, "pw_cnt2");
    wr(A_PRE, 32'd100);
    for (int k = 0; k < 6; k++)
      chk(A_CNT, pw_cnt[k], k == 3, $sformatf("pw_cnt%0d", k + 4));
    chk(A_PRE, 32'd100, 1'b0, "pw_preset");
    chk(A_CNT, 32'd98, 1'b0, "pw_cnt11");
    do_reset();
    chk(A_CNT,  32'd0, 1'b0, "mrst_count");
    chk(A_PRE,  32'd0, 1'b0, "mrst_preset");
    chk(A_CTRL, 32'd0, 1'b0, "mrst_ctrl");
    chk(A_CNT,  32'd0, 1'b0, "mrst_idle");

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: pending=%0d expected pending=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped interval timer that answers the pipeline's M-stage load/store traffic. The block is a bus responder beside the data memory: it decodes a 3-word register window, returns read data combinationally in the same cycle, and counts down from a preset value. It raises an interrupt request toward the CPU when the count expires, either once or periodically.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_7F00, byte address of the register window; bits [3:0] must be zero.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- addr  in  32  byte address from M stage; addr[1:0] ignored.
- we  in  1  write strobe, already qualified for this device.
- wdata  in  32  store data.
- rdata  out  32  read data, combinational from addr.
- irq  out  1  interrupt request, registered.

## Operation
- Window: hit when addr[31:4] == BASE_ADDR[31:4]. Word offset addr[3:2] selects the register: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
- Register access:
  - Reserved reads return 0; reserved writes are ignored.
  - Misses return rdata 0 and ignore we.
- CTRL:
  - [0] EN enables counting.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as one-shot.
  - [3] IM is the interrupt mask (1 = allowed).
  - [31:4] are read-as-zero and ignore writes.
- PRESET is read/write, 32 bits.
- COUNT is read-only; writes are ignored.
- FSM states are IDLE, LOAD, CNT and INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT. If EN=0, go to IDLE instead and leave COUNT unchanged.
  - CNT: if EN=0, go to IDLE and hold COUNT. Else if COUNT==0, set irq_flag and go to INT. Else COUNT <= COUNT-1.
  - INT, one-shot: clear EN, keep irq_flag, go to IDLE.
  - INT, auto-reload: clear irq_flag, go to LOAD.
- irq = irq_flag & IM, driven from registers only.
- Any write to CTRL clears irq_flag.
- Simultaneous events:
  - A CPU write to CTRL overrides the FSM's EN clear on the same edge.
  - An FSM flag-set beats a CTRL-write clear on the same edge, so no interrupt is lost.
- PRESET writes during CNT do not affect the current count; the new value is used at the next LOAD.
- A MODE change mid-count takes effect at the next INT.
- COUNT wraps nowhere; the decrement never goes below 0.

## Timing
- Reset:
  - CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE, irq=0.
  - A reset asserted mid-count aborts immediately and gives the same values.
- Reads have zero latency: rdata reflects register contents before the current edge.
- One-shot sequence, with the CTRL write (EN=1) taking effect on edge 0:
  - Edge 1: IDLE→LOAD.
  - Edge 2: COUNT=PRESET=N.
  - Edge 2+N: COUNT=0.
  - Edge 3+N: irq rises.
  - irq stays high until CTRL is written.
- Auto-reload:
  - irq is high for exactly one cycle per period.
  - Period is N+3 cycles (LOAD, N decrements, zero-detect, INT).
- PRESET=0 gives irq one edge after LOAD.

## Structure
- Shared package timer_pkg holds:
  - state encodings IDLE/LOAD/CNT/INT (2 bits);
  - register offsets CTRL=2'd0, PRESET=2'd1, COUNT=2'd2;
  - CTRL bit indices EN/MODE/IM;
  - mode codes.
- Single module, with no sub-module. Register decode and FSM are one always block plus combinational read mux.

## Test plan
- Reset, then read all three registers → 0; irq=0; read BASE_ADDR+0xC → 0; write to addr outside window → no register changes.
- PRESET=5, CTRL=4'b1001 (one-shot, IM) → COUNT 5,4,…,0; irq rises 8 cycles after CTRL edge; CTRL reads 4'b1000; irq held until CTRL written, then 0.
- PRESET=3, CTRL=4'b1011 (auto-reload) → irq one-cycle pulses every 6 cycles for ≥3 periods; COUNT reloads to 3 each period.
- Mid-count CTRL=0 at COUNT=7 of PRESET=10 → state IDLE, COUNT holds 7, no irq; re-enable → COUNT reloads 10.
- IM=0 one-shot, PRESET=2 → irq stays 0, EN cleared; then set IM=1 via CTRL write → irq stays 0 (flag cleared by write).
- PRESET write 100 during CNT of PRESET=4 → current period ends after 4; next auto-reload COUNT=100; reset asserted mid-count → all zero next cycle.
